// File: rtl/uart_pkg.sv
// Shared definitions for the DTM_UART framing stage: escape byte, command codes,
// register addresses, parser states and the payload length lookup.
package uart_pkg;

    localparam logic [7:0] ESC = 8'hB1;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_READ  = 3'd1,
        CMD_WRITE = 3'd2,
        CMD_RESET = 3'd3
    } cmd_e;

    localparam logic [4:0] ADDR_IDCODE = 5'h01;
    localparam logic [4:0] ADDR_DTMCS  = 5'h10;
    localparam logic [4:0] ADDR_DMI    = 5'h11;

    // Marks a cmd/addr combination that cannot start a valid frame.
    localparam logic [3:0] LEN_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_PAY_ESC
    } parser_state_e;

    function automatic logic [3:0] payload_len(input logic [2:0] cmd, input logic [4:0] addr);
        logic [3:0] len;
        len = LEN_INVALID;
        case (cmd)
            CMD_NOP, CMD_READ, CMD_RESET: len = 4'd0;
            CMD_WRITE: begin
                if (addr == ADDR_DMI) begin
                    len = 4'd6;
                end else if (addr == ADDR_DTMCS) begin
                    len = 4'd4;
                end else begin
                    len = LEN_INVALID;
                end
            end
            default: len = LEN_INVALID;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// ESC-framed command parser: un-escapes the UART byte stream and hands one decoded
// command per frame to the DTM over a single-entry ready/valid register.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 41,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  RX_VALID_I,
    input  logic [7:0]            RX_DATA_I,
    output logic                  CMD_VALID_O,
    input  logic                  CMD_READY_I,
    output logic [2:0]            CMD_O,
    output logic [4:0]            ADDR_O,
    output logic [DATA_WIDTH-1:0] DATA_O,
    output logic                  ERR_FRAME_O,
    output logic                  ERR_OVERRUN_O,
    output logic                  BUSY_O
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    parser_state_e         state, state_next;
    logic [2:0]            cmd_q, cmd_next;
    logic [4:0]            addr_q, addr_next;
    logic [3:0]            len_q, len_next;
    logic [3:0]            count_q, count_next;
    logic [DATA_WIDTH-1:0] data_q, data_next;
    logic [TW-1:0]         timer_q, timer_next;
    logic [3:0]            len_new;
    logic                  take_cmd;
    logic                  store;
    logic                  complete;
    logic                  frame_err;

    assign len_new = payload_len(RX_DATA_I[7:5], RX_DATA_I[4:0]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            timer_q <= '0;
        end else begin
            state   <= state_next;
            cmd_q   <= cmd_next;
            addr_q  <= addr_next;
            len_q   <= len_next;
            count_q <= count_next;
            data_q  <= data_next;
            timer_q <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_next   = cmd_q;
        addr_next  = addr_q;
        len_next   = len_q;
        count_next = count_q;
        data_next  = data_q;
        timer_next = timer_q;
        take_cmd   = 1'b0;
        store      = 1'b0;
        complete   = 1'b0;
        frame_err  = 1'b0;

        if (state == ST_IDLE || RX_VALID_I) begin
            timer_next = '0;
        end else if (timer_q == TIMER_MAX) begin
            frame_err  = 1'b1;
            state_next = ST_IDLE;
            timer_next = '0;
        end else begin
            timer_next = timer_q + TW'(1);
        end

        if (RX_VALID_I) begin
            case (state)
                ST_IDLE: begin
                    if (RX_DATA_I == ESC) state_next = ST_CMD;
                end
                ST_CMD: begin
                    if (RX_DATA_I == ESC) state_next = ST_IDLE;
                    else                  take_cmd   = 1'b1;
                end
                ST_PAYLOAD: begin
                    if (RX_DATA_I == ESC) state_next = ST_PAY_ESC;
                    else                  store      = 1'b1;
                end
                ST_PAY_ESC: begin
                    // A lone ESC inside a payload means the sender restarted a frame.
                    if (RX_DATA_I == ESC) begin
                        store = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                        take_cmd  = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        if (take_cmd) begin
            cmd_next   = RX_DATA_I[7:5];
            addr_next  = RX_DATA_I[4:0];
            len_next   = len_new;
            count_next = '0;
            data_next  = '0;
            if (len_new == LEN_INVALID) begin
                frame_err  = 1'b1;
                state_next = ST_IDLE;
            end else if (len_new == 4'd0) begin
                complete   = 1'b1;
                state_next = ST_IDLE;
            end else begin
                state_next = ST_PAYLOAD;
            end
        end

        // Bytes beyond DATA_WIDTH fall off the top of the shift.
        if (store) begin
            data_next  = data_q | (DATA_WIDTH'(RX_DATA_I) << {count_q, 3'b000});
            count_next = count_q + 4'd1;
            if (count_next == len_q) begin
                complete   = 1'b1;
                state_next = ST_IDLE;
            end else begin
                state_next = ST_PAYLOAD;
            end
        end
    end

    // Single-entry output register; an accept in the completion cycle frees the slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            CMD_VALID_O   <= 1'b0;
            CMD_O         <= '0;
            ADDR_O        <= '0;
            DATA_O        <= '0;
            ERR_FRAME_O   <= 1'b0;
            ERR_OVERRUN_O <= 1'b0;
        end else begin
            ERR_FRAME_O   <= frame_err;
            ERR_OVERRUN_O <= 1'b0;
            if (complete) begin
                if (!CMD_VALID_O || CMD_READY_I) begin
                    CMD_VALID_O <= 1'b1;
                    CMD_O       <= cmd_next;
                    ADDR_O      <= addr_next;
                    DATA_O      <= data_next;
                end else begin
                    ERR_OVERRUN_O <= 1'b1;
                end
            end else if (CMD_VALID_O && CMD_READY_I) begin
                CMD_VALID_O <= 1'b0;
            end
        end
    end

    assign BUSY_O = (state != ST_IDLE);

endmodule
